// File: rtl/alu_mem_datapath_pkg.sv
// -----------------------------------------------------------------------------
// alu_mem_datapath_pkg
// Shared definitions for the 8-bit processor execution slice: default widths
// for the data RAM and register file, and the operand-A select encoding used by
// the control FSM when steering the ALU's first operand.
// -----------------------------------------------------------------------------
package alu_mem_datapath_pkg;

  // Default geometry of the data RAM and register-file words.
  localparam int MEMORY_ADDRESS_BITS = 8;
  localparam int MEMORY_DATA_BITS    = 8;
  localparam int REGISTER_DATA_BITS  = 8;

  // Operand-A source as encoded on the a_sel control line.
  typedef enum logic {
    A_REG = 1'b0,  // register-file read port 0
    A_IMM = 1'b1   // instruction immediate
  } a_sel_e;

endpackage : alu_mem_datapath_pkg

// File: rtl/alu_mem_datapath_if.sv
// -----------------------------------------------------------------------------
// alu_mem_datapath_if
// Bundles the control, operand, result and memory signals that pass between
// the control FSM / register file (master) and the execution datapath (slave).
//
// Signals (direction seen from the master):
//   a_sel        out  operand-A select (0 = reg_a, 1 = imm)
//   reg_a        out  register-file read port 0 data
//   imm          out  instruction immediate
//   b            out  operand B (register-file read port 1 data)
//   subtract     out  0 = add, 1 = subtract
//   alu_a        in   selected operand A (debug export)
//   alu_result   in   ALU sum/difference
//   alu_cout     in   ALU carry out (subtract: 1 = no borrow)
//   alu_zero     in   1 when alu_result is zero
//   mem_addr     out  RAM address
//   mem_out_en   out  RAM read enable
//   mem_write_en out  RAM write enable
//   mem_wr_data  out  RAM write data
//   mem_rd_data  in   registered RAM read data
// -----------------------------------------------------------------------------
interface alu_mem_datapath_if #(
  parameter int ADDR_BITS = alu_mem_datapath_pkg::MEMORY_ADDRESS_BITS,
  parameter int DATA_BITS = alu_mem_datapath_pkg::MEMORY_DATA_BITS
);

  // Operand selection and ALU control
  logic                 a_sel;
  logic [DATA_BITS-1:0] reg_a;
  logic [DATA_BITS-1:0] imm;
  logic [DATA_BITS-1:0] b;
  logic                 subtract;

  // ALU results
  logic [DATA_BITS-1:0] alu_a;
  logic [DATA_BITS-1:0] alu_result;
  logic                 alu_cout;
  logic                 alu_zero;

  // Data RAM port
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_out_en;
  logic                 mem_write_en;
  logic [DATA_BITS-1:0] mem_wr_data;
  logic [DATA_BITS-1:0] mem_rd_data;

  // Control FSM / register-file side
  modport master (
    output a_sel, reg_a, imm, b, subtract,
    output mem_addr, mem_out_en, mem_write_en, mem_wr_data,
    input  alu_a, alu_result, alu_cout, alu_zero,
    input  mem_rd_data
  );

  // Execution datapath side
  modport slave (
    input  a_sel, reg_a, imm, b, subtract,
    input  mem_addr, mem_out_en, mem_write_en, mem_wr_data,
    output alu_a, alu_result, alu_cout, alu_zero,
    output mem_rd_data
  );

endinterface : alu_mem_datapath_if

// File: rtl/alu_mem_datapath_operand_mux2.sv
// -----------------------------------------------------------------------------
// operand_mux2
// Purely combinational 2:1 word selector used to pick the ALU's operand A.
//
// Ports:
//   sel  in   0 selects in0, 1 selects in1
//   in0  in   DATA_BITS-wide input 0
//   in1  in   DATA_BITS-wide input 1
//   out  out  selected word
// -----------------------------------------------------------------------------
module operand_mux2 #(
  parameter int DATA_BITS = 8
) (
  input  logic                 sel,
  input  logic [DATA_BITS-1:0] in0,
  input  logic [DATA_BITS-1:0] in1,
  output logic [DATA_BITS-1:0] out
);

  assign out = sel ? in1 : in0;

endmodule : operand_mux2

// File: rtl/alu_mem_datapath.sv
// -----------------------------------------------------------------------------
// alu_mem_datapath
// Execution slice of the 8-bit processor: operand-A select mux, add/subtract
// ALU with carry and zero flags, and a synchronous single-port data RAM with a
// registered read port.
//
// Ports:
//   clk    in   system clock, all state updates on the rising edge
//   reset  in   synchronous active-low reset; clears the read register and
//               every RAM word, overriding any same-cycle read or write
//   bus    slave modport of alu_mem_datapath_if (operands, ALU results and
//          the RAM address/enable/data signals)
//
// The mux and ALU are combinational and ignore reset. The RAM returns read
// data one cycle after the address is presented; a write in the same cycle as
// a read takes priority and leaves mem_rd_data unchanged.
// -----------------------------------------------------------------------------
module alu_mem_datapath
  import alu_mem_datapath_pkg::*;
#(
  parameter int ADDR_BITS = MEMORY_ADDRESS_BITS,
  parameter int DATA_BITS = MEMORY_DATA_BITS
) (
  input  logic                clk,
  input  logic                reset,
  alu_mem_datapath_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] alu_a;
  logic [DATA_BITS-1:0] b_eff;
  logic [DATA_BITS:0]   sum_ext;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] rd_data_q;

  // ---------------------------------------------------------------------------
  // Operand-A select
  // ---------------------------------------------------------------------------
  operand_mux2 #(
    .DATA_BITS (DATA_BITS)
  ) u_operand_mux2 (
    .sel (bus.a_sel == A_IMM),
    .in0 (bus.reg_a),
    .in1 (bus.imm),
    .out (alu_a)
  );

  // ---------------------------------------------------------------------------
  // ALU: subtraction as a + ~b + 1, so the carry out doubles as "no borrow".
  // ---------------------------------------------------------------------------
  always_comb begin
    b_eff   = bus.subtract ? ~bus.b : bus.b;
    sum_ext = {1'b0, alu_a} + {1'b0, b_eff} + {{DATA_BITS{1'b0}}, bus.subtract};
  end

  assign bus.alu_a      = alu_a;
  assign bus.alu_result = sum_ext[DATA_BITS-1:0];
  assign bus.alu_cout   = sum_ext[DATA_BITS];
  assign bus.alu_zero   = (sum_ext[DATA_BITS-1:0] == '0);

  // ---------------------------------------------------------------------------
  // Data RAM with registered read port. Write beats read; with neither enable
  // both the array and the read register hold.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_data_q <= '0;
    end else if (bus.mem_write_en) begin
      mem[bus.mem_addr] <= bus.mem_wr_data;
    end else if (bus.mem_out_en) begin
      rd_data_q <= mem[bus.mem_addr];
    end
  end

  assign bus.mem_rd_data = rd_data_q;

endmodule : alu_mem_datapath

// File: tb/tb_alu_mem_datapath.sv
// -----------------------------------------------------------------------------
// tb_alu_mem_datapath
// Self-checking bench for alu_mem_datapath: directed scenarios plus randomized
// ALU and RAM traffic checked against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_alu_mem_datapath;
  import alu_mem_datapath_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic reset;

  int tests;
  int fails;

  // Reference model state
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_rd;

  alu_mem_datapath_if #(.ADDR_BITS(AW), .DATA_BITS(DW)) bus ();

  alu_mem_datapath #(
    .ADDR_BITS (AW),
    .DATA_BITS (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: plain integer arithmetic. Returns {cout, result}.
  function automatic logic [DW:0] ref_alu(input int a, input int bv, input bit sub);
    int r;
    logic [DW:0] o;
    if (!sub) begin
      r = a + bv;
      o = {(r > 255), 8'(r % 256)};
    end else begin
      r = a - bv;
      o = {(a >= bv), 8'((r + 256) % 256)};
    end
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock cycle of RAM traffic with the reference model updated in step.
  task automatic mem_cycle(input logic oe, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.mem_out_en   = oe;
    bus.mem_write_en = we;
    bus.mem_addr     = addr;
    bus.mem_wr_data  = data;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      model_rd = '0;
    end else if (we) begin
      model_mem[addr] = data;
    end else if (oe) begin
      model_rd = model_mem[addr];
    end
    tick();
    bus.mem_out_en   = 1'b0;
    bus.mem_write_en = 1'b0;
  endtask

  task automatic set_alu(input logic sel, input logic [DW-1:0] ra, input logic [DW-1:0] im,
                         input logic [DW-1:0] bv, input logic sub);
    bus.a_sel    = sel;
    bus.reg_a    = ra;
    bus.imm      = im;
    bus.b        = bv;
    bus.subtract = sub;
    #1;
  endtask

  task automatic test_reset();
    // Dirty a location first so the reset clear is observable.
    reset = 1'b1;
    mem_cycle(1'b0, 1'b1, 8'h10, 8'h5A);
    reset = 1'b0;
    mem_cycle(1'b0, 1'b0, 8'h00, 8'h00);
    tests++;
    if (bus.mem_rd_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_rd: got %h expected 00", bus.mem_rd_data);
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [AW-1:0] a;
      a = (k == 0) ? 8'h10 : 8'($urandom_range(0, 255));
      mem_cycle(1'b1, 1'b0, a, 8'h00);
      tests++;
      if (bus.mem_rd_data !== 8'h00) begin
        fails++;
        $display("FAIL reset_word[%h]: got %h expected 00", a, bus.mem_rd_data);
      end
    end
  endtask

  task automatic test_ram_basic();
    mem_cycle(1'b0, 1'b1, 8'h03, 8'hA5);
    mem_cycle(1'b1, 1'b0, 8'h03, 8'h00);
    tests++;
    if (bus.mem_rd_data !== 8'hA5) begin
      fails++;
      $display("FAIL raw_03: got %h expected a5", bus.mem_rd_data);
    end
    mem_cycle(1'b1, 1'b0, 8'h04, 8'h00);
    tests++;
    if (bus.mem_rd_data !== 8'h00) begin
      fails++;
      $display("FAIL read_04: got %h expected 00", bus.mem_rd_data);
    end
    // Idle cycle: read register holds.
    mem_cycle(1'b0, 1'b0, 8'h03, 8'h00);
    tests++;
    if (bus.mem_rd_data !== 8'h00) begin
      fails++;
      $display("FAIL idle_hold: got %h expected 00", bus.mem_rd_data);
    end
  endtask

  task automatic test_alu_add();
    set_alu(1'b0, 8'h7F, 8'h00, 8'h01, 1'b0);
    tests++;
    if ({bus.alu_a, bus.alu_result, bus.alu_cout, bus.alu_zero} !== {8'h7F, 8'h80, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL add_7f_01: got a=%h r=%h c=%b z=%b expected a=7f r=80 c=0 z=0",
               bus.alu_a, bus.alu_result, bus.alu_cout, bus.alu_zero);
    end
    set_alu(1'b1, 8'h7F, 8'hFF, 8'h01, 1'b0);
    tests++;
    if ({bus.alu_a, bus.alu_result, bus.alu_cout, bus.alu_zero} !== {8'hFF, 8'h00, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL add_imm_ff_01: got a=%h r=%h c=%b z=%b expected a=ff r=00 c=1 z=1",
               bus.alu_a, bus.alu_result, bus.alu_cout, bus.alu_zero);
    end
  endtask

  task automatic test_alu_sub();
    set_alu(1'b0, 8'h05, 8'h00, 8'h05, 1'b1);
    tests++;
    if ({bus.alu_result, bus.alu_cout, bus.alu_zero} !== {8'h00, 1'b1, 1'b1}) begin
      fails++;
      $display("FAIL sub_05_05: got r=%h c=%b z=%b expected r=00 c=1 z=1",
               bus.alu_result, bus.alu_cout, bus.alu_zero);
    end
    set_alu(1'b0, 8'h03, 8'h00, 8'h05, 1'b1);
    tests++;
    if ({bus.alu_result, bus.alu_cout, bus.alu_zero} !== {8'hFE, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL sub_03_05: got r=%h c=%b z=%b expected r=fe c=0 z=0",
               bus.alu_result, bus.alu_cout, bus.alu_zero);
    end
  endtask

  task automatic test_random_alu();
    for (int k = 0; k < 200; k++) begin
      logic sel, sub;
      logic [DW-1:0] ra, im, bv, a_exp;
      logic [DW:0] exp_o;
      sel = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      ra  = 8'($urandom_range(0, 255));
      im  = 8'($urandom_range(0, 255));
      bv  = (k % 8 == 0) ? (sel ? im : ra) : 8'($urandom_range(0, 255));
      set_alu(sel, ra, im, bv, sub);
      a_exp = sel ? im : ra;
      exp_o = ref_alu(int'(a_exp), int'(bv), sub);
      tests++;
      if ({bus.alu_a, bus.alu_cout, bus.alu_result, bus.alu_zero} !==
          {a_exp, exp_o, (exp_o[DW-1:0] == 8'h00)}) begin
        fails++;
        $display("FAIL rand_alu sel=%b sub=%b ra=%h im=%h b=%h: got a=%h c=%b r=%h z=%b expected a=%h c=%b r=%h",
                 sel, sub, ra, im, bv, bus.alu_a, bus.alu_cout, bus.alu_result, bus.alu_zero,
                 a_exp, exp_o[DW], exp_o[DW-1:0]);
      end
    end
  endtask

  task automatic test_write_priority();
    mem_cycle(1'b0, 1'b1, 8'h21, 8'h11);
    mem_cycle(1'b1, 1'b0, 8'h21, 8'h00);
    tests++;
    if (bus.mem_rd_data !== 8'h11) begin
      fails++;
      $display("FAIL prio_setup: got %h expected 11", bus.mem_rd_data);
    end
    mem_cycle(1'b1, 1'b1, 8'h20, 8'h3C);
    tests++;
    if (bus.mem_rd_data !== 8'h11) begin
      fails++;
      $display("FAIL prio_hold: got %h expected 11", bus.mem_rd_data);
    end
    mem_cycle(1'b1, 1'b0, 8'h20, 8'h00);
    tests++;
    if (bus.mem_rd_data !== 8'h3C) begin
      fails++;
      $display("FAIL prio_read_20: got %h expected 3c", bus.mem_rd_data);
    end
  endtask

  task automatic test_reset_mid();
    mem_cycle(1'b0, 1'b1, 8'hFF, 8'h77);
    mem_cycle(1'b1, 1'b0, 8'hFF, 8'h00);
    tests++;
    if (bus.mem_rd_data !== 8'h77) begin
      fails++;
      $display("FAIL rst_mid_setup: got %h expected 77", bus.mem_rd_data);
    end
    reset = 1'b0;
    set_alu(1'b0, 8'h10, 8'h00, 8'h20, 1'b0);
    tests++;
    if (bus.alu_result !== 8'h30) begin
      fails++;
      $display("FAIL alu_in_reset: got %h expected 30", bus.alu_result);
    end
    mem_cycle(1'b1, 1'b1, 8'hFF, 8'h99);
    tests++;
    if (bus.mem_rd_data !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_rd: got %h expected 00", bus.mem_rd_data);
    end
    reset = 1'b1;
    mem_cycle(1'b1, 1'b0, 8'hFF, 8'h00);
    tests++;
    if (bus.mem_rd_data !== 8'h00) begin
      fails++;
      $display("FAIL rst_mid_ff: got %h expected 00", bus.mem_rd_data);
    end
  endtask

  task automatic test_random_ram();
    for (int k = 0; k < 400; k++) begin
      logic oe, we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      oe = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 3) == 0);
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      d  = 8'($urandom_range(0, 255));
      mem_cycle(oe, we, a, d);
      tests++;
      if (bus.mem_rd_data !== model_rd) begin
        fails++;
        $display("FAIL rand_ram k=%0d oe=%b we=%b addr=%h: got %h expected %h",
                 k, oe, we, a, bus.mem_rd_data, model_rd);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_rd = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    reset            = 1'b1;
    bus.a_sel        = A_REG;
    bus.reg_a        = '0;
    bus.imm          = '0;
    bus.b            = '0;
    bus.subtract     = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_out_en   = 1'b0;
    bus.mem_write_en = 1'b0;
    bus.mem_wr_data  = '0;
    tick();

    test_reset();
    test_ram_basic();
    test_alu_add();
    test_alu_sub();
    test_random_alu();
    test_write_priority();
    test_reset_mid();
    test_random_ram();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_alu_mem_datapath

// File: doc/alu_mem_datapath.md
Name: alu_mem_datapath

Overview:
Combined execution datapath slice for the 8-bit processor: a 2:1 operand-A select mux, an add/subtract ALU with carry and zero flags, and a synchronous single-port data RAM. It sits between the control FSM/register file and memory. The FSM drives selects, enables and addresses. The register file supplies operands and consumes the ALU result and RAM read data.

Parameters:
ADDR_BITS, 8, RAM address width; depth = 2**ADDR_BITS words.
DATA_BITS, 8, width of ALU operands, result and RAM words.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
a_sel  input  1  operand-A select: 0 = reg_a, 1 = imm.
reg_a  input  DATA_BITS  register-file read port 0 data.
imm  input  DATA_BITS  instruction immediate.
b  input  DATA_BITS  operand B (register-file read port 1 data).
subtract  input  1  0 = add, 1 = subtract.
alu_a  output  DATA_BITS  selected operand A (mux output, exported for debug).
alu_result  output  DATA_BITS  ALU sum/difference.
alu_cout  output  1  ALU carry out.
alu_zero  output  1  1 when alu_result == 0.
mem_addr  input  ADDR_BITS  RAM address.
mem_out_en  input  1  read enable.
mem_write_en  input  1  write enable.
mem_wr_data  input  DATA_BITS  write data.
mem_rd_data  output  DATA_BITS  registered read data.

Behaviour:
- Mux, combinational: alu_a = a_sel ? imm : reg_a.
- ALU, combinational, zero latency:
  - Computes {alu_cout, alu_result} = alu_a + (subtract ? ~b : b) + subtract, at DATA_BITS+1 width.
  - Add: cout = unsigned overflow.
  - Subtract: cout = 1 means no borrow (alu_a >= b unsigned).
  - Results wrap modulo 2**DATA_BITS.
  - alu_zero = (alu_result == 0).
  - Unaffected by reset.
- RAM, synchronous, one array of 2**ADDR_BITS x DATA_BITS:
  - Write: on rising clk with mem_write_en=1, mem[mem_addr] <= mem_wr_data.
  - Read: on rising clk with mem_out_en=1 and mem_write_en=0, mem_rd_data <= mem[mem_addr]. Data is valid the cycle after the address is presented (1-cycle latency).
  - Simultaneous out_en and write_en: write wins, mem_rd_data holds (no write-through).
  - out_en=0 and write_en=0: array and mem_rd_data hold.
  - Read-after-write to the same address in the next cycle returns the new data.
  - Address wraps naturally; all 2**ADDR_BITS locations are addressable.
- Reset (reset==0 at a rising edge):
  - mem_rd_data <= 0 and every RAM word <= 0.
  - Reset has priority over a same-cycle write or read, which is discarded.
  - Reset asserted mid-sequence discards any pending read result.
  - Combinational outputs track their inputs during reset.
- No X-propagation from undriven inputs is required; no tristate buses (separate read/write data ports).

Decomposition:
- Shared package: DATA_BITS/ADDR_BITS defaults (MEMORY_ADDRESS_BITS, MEMORY_DATA_BITS, REGISTER_DATA_BITS) and an a_sel encoding typedef (A_REG=0, A_IMM=1).
- One natural sub-module: operand_mux2 (parameterised DATA_BITS, 2:1 combinational).
- ALU and RAM are coded inline as separate always blocks.

Test Plan:
- reset=0 one cycle, then mem_out_en=1 at addr 0x10 -> next cycle mem_rd_data=0x00; all sampled words 0.
- Write 0xA5 to 0x03 (write_en=1), next cycle out_en=1 addr 0x03 -> following cycle mem_rd_data=0xA5. Read of 0x04 -> 0x00.
- a_sel=0, reg_a=0x7F, b=0x01, subtract=0 -> alu_a=0x7F, result=0x80, cout=0, zero=0. Then a_sel=1, imm=0xFF, b=0x01 -> result=0x00, cout=1, zero=1.
- subtract=1, reg_a=0x05, b=0x05 -> result=0x00, cout=1, zero=1. reg_a=0x03, b=0x05 -> result=0xFE, cout=0.
- write_en=1 and out_en=1 same cycle, addr 0x20, data 0x3C, with prior mem_rd_data=0x11 -> mem_rd_data stays 0x11; subsequent read of 0x20 -> 0x3C.
- Write 0x77 to 0xFF, then reset=0 in the cycle of a read of 0xFF -> mem_rd_data=0x00; later read of 0xFF -> 0x00.
